// File: rtl/vsync_controller_pkg.sv
// Shared vertical timing constants and frame-phase encoding for the VGA vertical path.
package vsync_controller_pkg;

  localparam int SYNC_LINES_D  = 2;
  localparam int BACK_LINES_D  = 29;
  localparam int DISP_LINES_D  = 480;
  localparam int FRONT_LINES_D = 10;
  localparam int LINE_REPEAT_D = 5;
  localparam int ROWS_D        = 96;

  localparam int LINE_W = 9;
  localparam int REP_W  = 3;
  localparam int ROW_W  = 7;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_BACK  = 2'd1,
    ST_DISP  = 2'd2,
    ST_FRONT = 2'd3
  } vstate_t;

  function automatic vstate_t next_phase(input vstate_t s);
    case (s)
      ST_SYNC:  return ST_BACK;
      ST_BACK:  return ST_DISP;
      ST_DISP:  return ST_FRONT;
      default:  return ST_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/vsync_controller_vline_counter.sv
// Line-event enabled up-counter that wraps at a programmable last value and can be cleared.
module vline_counter
  import vsync_controller_pkg::*;
#(
  parameter int W = LINE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         term
);

  assign term = (cnt == last);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= term ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vsync_controller.sv
// Vertical frame sequencer: counts line starts, steps SYNC/BACK/DISP/FRONT, and
// produces vsync, vdisplay, the image row index and a frame-start strobe.
module vsync_controller
  import vsync_controller_pkg::*;
#(
  parameter int SYNC_LINES  = SYNC_LINES_D,
  parameter int BACK_LINES  = BACK_LINES_D,
  parameter int DISP_LINES  = DISP_LINES_D,
  parameter int FRONT_LINES = FRONT_LINES_D,
  parameter int LINE_REPEAT = LINE_REPEAT_D,
  parameter int ROWS        = ROWS_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_line,
  output logic             vsync,
  output logic             vdisplay,
  output logic [ROW_W-1:0] vpixel,
  output logic             new_frame
);

  vstate_t            state;
  vstate_t            state_nxt;
  logic               new_line_q;
  logic               ev;
  logic [LINE_W-1:0]  line_cnt;
  logic [LINE_W-1:0]  line_last;
  logic               line_term;
  logic [REP_W-1:0]   rep_cnt;
  logic               rep_term;
  logic               in_disp;
  logic               phase_end;
  logic               leave_disp;
  logic               vsync_nxt;
  logic               vdisplay_nxt;
  logic               new_frame_nxt;
  logic [ROW_W-1:0]   vpixel_nxt;

  // Rising-edge detect so a held new_line is counted only once.
  always_ff @(posedge clk) begin
    if (reset) new_line_q <= 1'b0;
    else       new_line_q <= new_line;
  end

  assign ev         = new_line & ~new_line_q;
  assign in_disp    = (state == ST_DISP);
  assign phase_end  = ev & line_term;
  assign leave_disp = phase_end & in_disp;

  always_comb begin
    line_last = '0;
    case (state)
      ST_SYNC:  line_last = LINE_W'(SYNC_LINES - 1);
      ST_BACK:  line_last = LINE_W'(BACK_LINES - 1);
      ST_DISP:  line_last = LINE_W'(DISP_LINES - 1);
      default:  line_last = LINE_W'(FRONT_LINES - 1);
    endcase
  end

  vline_counter #(.W(LINE_W)) u_line_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ev),
    .clear (1'b0),
    .last  (line_last),
    .cnt   (line_cnt),
    .term  (line_term)
  );

  // The last DISP line also wraps rep_cnt; the clear makes the exit state explicit.
  vline_counter #(.W(REP_W)) u_rep_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ev & in_disp),
    .clear (leave_disp),
    .last  (REP_W'(LINE_REPEAT - 1)),
    .cnt   (rep_cnt),
    .term  (rep_term)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (phase_end) state_nxt = next_phase(state);
  end

  always_comb begin
    vsync_nxt     = (state_nxt != ST_SYNC);
    vdisplay_nxt  = (state_nxt == ST_DISP);
    new_frame_nxt = phase_end & (state == ST_FRONT);
    vpixel_nxt    = vpixel;
    if (leave_disp)                  vpixel_nxt = '0;
    else if (ev && in_disp && rep_term) vpixel_nxt = vpixel + ROW_W'(1);
  end

  // Registered outputs, updated on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync     <= 1'b0;
      vdisplay  <= 1'b0;
      vpixel    <= '0;
      new_frame <= 1'b0;
    end else begin
      vsync     <= vsync_nxt;
      vdisplay  <= vdisplay_nxt;
      vpixel    <= vpixel_nxt;
      new_frame <= new_frame_nxt;
    end
  end

endmodule

// File: tb/tb_vsync_controller.sv
// Bench for vsync_controller: directed vector table, corner sequences and a
// random line stream checked against a frame-position reference model.
module tb_vsync_controller;

  localparam int SYNC_L  = 2;
  localparam int BACK_L  = 29;
  localparam int DISP_L  = 480;
  localparam int FRONT_L = 10;
  localparam int REP_L   = 5;
  localparam int TOTAL_L = SYNC_L + BACK_L + DISP_L + FRONT_L;
  localparam int DISP_START = SYNC_L + BACK_L;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       new_line = 1'b0;
  logic       vsync;
  logic       vdisplay;
  logic [6:0] vpixel;
  logic       new_frame;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: position of the current line within the frame.
  int m_line = 0;
  bit m_prev = 1'b0;
  bit m_nf = 1'b0;

  typedef struct {
    logic       rst;
    logic       nl;
    logic       vs;
    logic       vd;
    logic [6:0] vp;
    logic       nf;
  } vec_t;

  vec_t tbl[17];

  vsync_controller dut (
    .clk       (clk),
    .reset     (reset),
    .new_line  (new_line),
    .vsync     (vsync),
    .vdisplay  (vdisplay),
    .vpixel    (vpixel),
    .new_frame (new_frame)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic r, input logic nl);
    reset = r;
    new_line = nl;
    @(posedge clk);
    if (r) begin
      m_line = 0;
      m_prev = 1'b0;
      m_nf = 1'b0;
    end else begin
      m_nf = 1'b0;
      if (nl && !m_prev) begin
        if (m_line == TOTAL_L - 1) begin
          m_line = 0;
          m_nf = 1'b1;
        end else begin
          m_line++;
        end
      end
      m_prev = nl;
    end
    #1;
    cyc++;
  endtask

  task automatic check_model();
    bit vd_e;
    int vp_e;
    vd_e = (m_line >= DISP_START) && (m_line < DISP_START + DISP_L);
    vp_e = vd_e ? (m_line - DISP_START) / REP_L : 0;
    chk("vsync", int'(vsync), int'(m_line >= SYNC_L));
    chk("vdisplay", int'(vdisplay), int'(vd_e));
    chk("vpixel", int'(vpixel), vp_e);
    chk("new_frame", int'(new_frame), int'(m_nf));
  endtask

  task automatic line_checked(input int period);
    cycle(1'b0, 1'b1);
    check_model();
    for (int k = 1; k < period; k++) begin
      cycle(1'b0, 1'b0);
      check_model();
    end
  endtask

  initial begin
    // Reset held cycles 3..6; pulse coincides with reset; held-high counts once.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0};
    for (int i = 6; i < 15; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0};

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].rst, tbl[i].nl);
      chk($sformatf("tbl%0d.vsync", i), int'(vsync), int'(tbl[i].vs));
      chk($sformatf("tbl%0d.vdisplay", i), int'(vdisplay), int'(tbl[i].vd));
      chk($sformatf("tbl%0d.vpixel", i), int'(vpixel), int'(tbl[i].vp));
      chk($sformatf("tbl%0d.new_frame", i), int'(new_frame), int'(tbl[i].nf));
    end
    cycle(1'b0, 1'b0);
    check_model();

    // Random line stream, including held-high runs, over roughly three frames.
    for (int i = 0; i < 8000; i++) begin
      cycle(1'b0, ($urandom_range(0, 3) == 0));
      check_model();
    end
    cycle(1'b0, 1'b0);
    check_model();

    // Frame period and per-frame sync/display widths at a fixed 4-clock line.
    begin
      int guard;
      int per;
      int vs_low;
      int vd_hi;
      guard = 0;
      while (!new_frame && guard < 4 * TOTAL_L + 8) begin
        cycle(1'b0, (guard % 4) == 0);
        check_model();
        guard++;
      end
      chk("sync_to_frame", int'(new_frame), 1);
      per = 0; vs_low = 0; vd_hi = 0;
      do begin
        if (!vsync) vs_low++;
        if (vdisplay) vd_hi++;
        cycle(1'b0, (per % 4) == 3);
        check_model();
        per++;
      end while (!new_frame && per < 4 * TOTAL_L + 8);
      chk("frame_period", per, 4 * TOTAL_L);
      chk("vsync_low_clks", vs_low, 4 * SYNC_L);
      chk("vdisplay_clks", vd_hi, 4 * DISP_L);
    end

    // Reset during DISP at row 40, then a full restart through the display window.
    begin
      int guard;
      guard = 0;
      while (m_line != DISP_START + 40 * REP_L + 2 && guard < 2 * TOTAL_L) begin
        line_checked(3);
        guard++;
      end
      chk("row40_reached", int'(vpixel), 40);
      cycle(1'b1, 1'b0);
      chk("mid_reset.vsync", int'(vsync), 0);
      chk("mid_reset.vdisplay", int'(vdisplay), 0);
      chk("mid_reset.vpixel", int'(vpixel), 0);
      chk("mid_reset.new_frame", int'(new_frame), 0);
      cycle(1'b0, 1'b0);
      check_model();
      guard = 0;
      while (m_line != DISP_START + DISP_L - 1 && guard < TOTAL_L) begin
        line_checked(3);
        guard++;
      end
      chk("last_disp_line.vpixel", int'(vpixel), 95);
      chk("last_disp_line.vdisplay", int'(vdisplay), 1);
      cycle(1'b0, 1'b1);
      chk("first_front.vpixel", int'(vpixel), 0);
      chk("first_front.vdisplay", int'(vdisplay), 0);
      chk("first_front.vsync", int'(vsync), 1);
      cycle(1'b0, 1'b0);
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
